// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared widths, field slices, field bounds, FSM states and saturating negation for the ball path
package pingpong_pkg;

  // Bus widths of the muxed / feedback ball state
  localparam int LOC_W = 22;
  localparam int VEL_W = 32;
  localparam int ANG_W = 17;

  // Per-axis widths: stored position, stored velocity, signed advance sum
  localparam int POS_W = 11;
  localparam int SPD_W = 16;
  localparam int SUM_W = 13;

  // Field slices inside the packed buses
  localparam int LOC_X_HI = 21;
  localparam int LOC_X_LO = 11;
  localparam int LOC_Y_HI = 10;
  localparam int LOC_Y_LO = 0;
  localparam int VEL_X_HI = 31;
  localparam int VEL_X_LO = 16;
  localparam int VEL_Y_HI = 15;
  localparam int VEL_Y_LO = 0;

  // Default playfield geometry (pixels)
  localparam int DEF_X_MIN  = 0;
  localparam int DEF_X_MAX  = 639;
  localparam int DEF_Y_MIN  = 0;
  localparam int DEF_Y_MAX  = 479;
  localparam int DEF_BALL_R = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CALC,
    OVER
  } state_t;

  // Negate a velocity; the most negative value has no positive twin, so clip it
  function automatic logic signed [SPD_W-1:0] neg_sat_spd(input logic signed [SPD_W-1:0] v);
    if (v == {1'b1, {(SPD_W-1){1'b0}}}) begin
      return {1'b0, {(SPD_W-1){1'b1}}};
    end
    return -v;
  endfunction

  // Same clipping negation for the angle/spin field
  function automatic logic signed [ANG_W-1:0] neg_sat_ang(input logic signed [ANG_W-1:0] a);
    if (a == {1'b1, {(ANG_W-1){1'b0}}}) begin
      return {1'b0, {(ANG_W-1){1'b1}}};
    end
    return -a;
  endfunction

endpackage

// File: rtl/ball_step_engine_if.sv
// rtl/ball_step_engine_if.sv - mux-side bus between the serve/feedback value mux and the step engine
interface ball_step_engine_if;
  import pingpong_pkg::*;

  logic             serve;
  logic             tick;
  logic             paddle_hit;
  logic [LOC_W-1:0] location_in;
  logic [VEL_W-1:0] velocity_in;
  logic [ANG_W-1:0] angle_in;

  logic             value_select;
  logic [LOC_W-1:0] location_fb;
  logic [VEL_W-1:0] velocity_fb;
  logic [ANG_W-1:0] angle_fb;
  logic             step_done;
  logic             wall_hit;
  logic             miss_top;
  logic             miss_bot;

  // Mux / game-control side
  modport master (
    output serve, tick, paddle_hit, location_in, velocity_in, angle_in,
    input  value_select, location_fb, velocity_fb, angle_fb,
    input  step_done, wall_hit, miss_top, miss_bot
  );

  // Step engine side
  modport slave (
    input  serve, tick, paddle_hit, location_in, velocity_in, angle_in,
    output value_select, location_fb, velocity_fb, angle_fb,
    output step_done, wall_hit, miss_top, miss_bot
  );

endinterface

// File: rtl/axis_reflect.sv
// rtl/axis_reflect.sv - one axis: advance position by velocity and mirror it off the lo/hi bounds
module axis_reflect
  import pingpong_pkg::*;
#(
  parameter int LO = 4,
  parameter int HI = 635
) (
  input  logic [POS_W-1:0]        pos_i,
  input  logic signed [SPD_W-1:0] vel_i,
  output logic [POS_W-1:0]        pos_o,
  output logic signed [SPD_W-1:0] vel_o,
  output logic                    below_lo_o,
  output logic                    above_hi_o
);

  localparam logic signed [SUM_W-1:0] LO_S = SUM_W'(LO);
  localparam logic signed [SUM_W-1:0] HI_S = SUM_W'(HI);

  logic signed [SUM_W-1:0] sum;

  // Unreflected advance: position zero-extended, velocity taken at the sum width
  assign sum = $signed({{(SUM_W-POS_W){1'b0}}, pos_i}) + $signed(vel_i[SUM_W-1:0]);

  // Landing exactly on a bound is still inside the field
  assign below_lo_o = sum < LO_S;
  assign above_hi_o = sum > HI_S;

  // Mirror the overshoot about the crossed bound and reverse the velocity
  always_comb begin
    pos_o = sum[POS_W-1:0];
    vel_o = vel_i;
    if (below_lo_o) begin
      pos_o = POS_W'((LO_S <<< 1) - sum);
      vel_o = neg_sat_spd(vel_i);
    end else if (above_hi_o) begin
      pos_o = POS_W'((HI_S <<< 1) - sum);
      vel_o = neg_sat_spd(vel_i);
    end
  end

endmodule

// File: rtl/ball_step_engine.sv
// rtl/ball_step_engine.sv - latches the muxed ball state, steps it per frame tick, reflects/misses; BALL_SPIN_EN adds spin
module ball_step_engine
  import pingpong_pkg::*;
#(
  parameter int X_MIN  = DEF_X_MIN,
  parameter int X_MAX  = DEF_X_MAX,
  parameter int Y_MIN  = DEF_Y_MIN,
  parameter int Y_MAX  = DEF_Y_MAX,
  parameter int BALL_R = DEF_BALL_R
`ifdef BALL_SPIN_EN
  ,
  parameter int VMAX   = 64
`endif
) (
  input logic               clk,
  input logic               rst,
  ball_step_engine_if.slave bus
);

  localparam logic [POS_W-1:0] Y_LO_POS = POS_W'(Y_MIN + BALL_R);
  localparam logic [POS_W-1:0] Y_HI_POS = POS_W'(Y_MAX - BALL_R);

  state_t state_q, state_d;

  logic [LOC_W-1:0] loc_q, loc_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [ANG_W-1:0] ang_q, ang_d;
  logic             paddle_q, paddle_d;
  logic             step_done_q, step_done_d;
  logic             wall_hit_q, wall_hit_d;
  logic             miss_top_q, miss_top_d;
  logic             miss_bot_q, miss_bot_d;
  logic             value_select;

  logic [POS_W-1:0]        x_cur, y_cur, x_next, y_adv, y_step;
  logic signed [SPD_W-1:0] vx_cur, vy_cur, vx_eff, vx_next, vy_step, y_vel_unused;
  logic signed [ANG_W-1:0] ang_cur, ang_pre, ang_step;
  logic                    x_below, x_above, y_below, y_above;
  logic                    step_wall, step_miss_top, step_miss_bot;

  assign x_cur   = loc_q[LOC_X_HI:LOC_X_LO];
  assign y_cur   = loc_q[LOC_Y_HI:LOC_Y_LO];
  assign vx_cur  = $signed(vel_q[VEL_X_HI:VEL_X_LO]);
  assign vy_cur  = $signed(vel_q[VEL_Y_HI:VEL_Y_LO]);
  assign ang_cur = $signed(ang_q);

`ifdef BALL_SPIN_EN
  localparam logic signed [SPD_W+1:0] VMAX_P = (SPD_W+2)'(VMAX);
  localparam logic signed [SPD_W+1:0] VMAX_N = -VMAX_P;

  logic signed [ANG_W-1:0] ang_shift;
  logic signed [SPD_W+1:0] vx_spin_sum;

  assign ang_shift   = ang_cur >>> 8;
  assign vx_spin_sum = $signed({{2{vx_cur[SPD_W-1]}}, vx_cur})
                     + $signed({ang_shift[ANG_W-1], ang_shift});

  // Spin bends vx before the wall test; the result is clipped to the speed limit
  always_comb begin
    vx_eff = vx_spin_sum[SPD_W-1:0];
    if (vx_spin_sum > VMAX_P) begin
      vx_eff = SPD_W'(VMAX_P);
    end else if (vx_spin_sum < VMAX_N) begin
      vx_eff = SPD_W'(VMAX_N);
    end
  end

  // Spin bleeds off by one unit per step towards zero
  always_comb begin
    ang_pre = ang_cur;
    if (ang_cur[ANG_W-1]) begin
      ang_pre = ang_cur + 17'sd1;
    end else if (ang_cur != '0) begin
      ang_pre = ang_cur - 17'sd1;
    end
  end
`else
  assign vx_eff  = vx_cur;
  assign ang_pre = ang_cur;
`endif

  axis_reflect #(
    .LO (X_MIN + BALL_R),
    .HI (X_MAX - BALL_R)
  ) u_x_axis (
    .pos_i      (x_cur),
    .vel_i      (vx_eff),
    .pos_o      (x_next),
    .vel_o      (vx_next),
    .below_lo_o (x_below),
    .above_hi_o (x_above)
  );

  // Y never reflects off the bounds; only the compares and the plain advance are used
  axis_reflect #(
    .LO (Y_MIN + BALL_R),
    .HI (Y_MAX - BALL_R)
  ) u_y_axis (
    .pos_i      (y_cur),
    .vel_i      (vy_cur),
    .pos_o      (y_adv),
    .vel_o      (y_vel_unused),
    .below_lo_o (y_below),
    .above_hi_o (y_above)
  );

  // Combine both axes into the post-step ball state; a paddle contact beats a miss
  always_comb begin
    step_wall     = x_below | x_above;
    ang_step      = step_wall ? neg_sat_ang(ang_pre) : ang_pre;
    step_miss_top = 1'b0;
    step_miss_bot = 1'b0;
    vy_step       = vy_cur;
    y_step        = y_adv;
    if (paddle_q) begin
      vy_step = neg_sat_spd(vy_cur);
      y_step  = y_cur;
    end else if (y_below) begin
      step_miss_top = 1'b1;
      y_step        = Y_LO_POS;
    end else if (y_above) begin
      step_miss_bot = 1'b1;
      y_step        = Y_HI_POS;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; serve restarts from any waiting or computing state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.serve) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.serve) begin
          state_d = LOAD;
        end else if (bus.tick) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (bus.serve) begin
          state_d = LOAD;
        end else if (step_miss_top || step_miss_bot) begin
          state_d = OVER;
        end else begin
          state_d = RUN;
        end
      end
      OVER: if (bus.serve) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: feed the mux from feedback only while a rally is live
  always_comb begin
    value_select = (state_q == RUN) || (state_q == CALC);
  end

  // Datapath next state: LOAD captures the mux, CALC commits a step and fires its pulses
  always_comb begin
    loc_d       = loc_q;
    vel_d       = vel_q;
    ang_d       = ang_q;
    paddle_d    = paddle_q;
    step_done_d = 1'b0;
    wall_hit_d  = 1'b0;
    miss_top_d  = 1'b0;
    miss_bot_d  = 1'b0;
    case (state_q)
      LOAD: begin
        loc_d = bus.location_in;
        vel_d = bus.velocity_in;
        ang_d = bus.angle_in;
      end
      RUN: begin
        if (bus.tick && !bus.serve) begin
          paddle_d = bus.paddle_hit;
        end
      end
      CALC: begin
        loc_d       = {x_next, y_step};
        vel_d       = {vx_next, vy_step};
        ang_d       = ang_step;
        step_done_d = 1'b1;
        wall_hit_d  = step_wall;
        miss_top_d  = step_miss_top;
        miss_bot_d  = step_miss_bot;
      end
      default: ;
    endcase
  end

  // Datapath registers: feedback buses, sampled paddle contact and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loc_q       <= '0;
      vel_q       <= '0;
      ang_q       <= '0;
      paddle_q    <= 1'b0;
      step_done_q <= 1'b0;
      wall_hit_q  <= 1'b0;
      miss_top_q  <= 1'b0;
      miss_bot_q  <= 1'b0;
    end else begin
      loc_q       <= loc_d;
      vel_q       <= vel_d;
      ang_q       <= ang_d;
      paddle_q    <= paddle_d;
      step_done_q <= step_done_d;
      wall_hit_q  <= wall_hit_d;
      miss_top_q  <= miss_top_d;
      miss_bot_q  <= miss_bot_d;
    end
  end

  assign bus.value_select = value_select;
  assign bus.location_fb  = loc_q;
  assign bus.velocity_fb  = vel_q;
  assign bus.angle_fb     = ang_q;
  assign bus.step_done    = step_done_q;
  assign bus.wall_hit     = wall_hit_q;
  assign bus.miss_top     = miss_top_q;
  assign bus.miss_bot     = miss_bot_q;

endmodule

// File: tb/tb_ball_step_engine.sv
// tb/tb_ball_step_engine.sv - scoreboard bench for ball_step_engine with a behavioural rally model
module tb_ball_step_engine;
  import pingpong_pkg::*;

  localparam int XLO = DEF_X_MIN + DEF_BALL_R;
  localparam int XHI = DEF_X_MAX - DEF_BALL_R;
  localparam int YLO = DEF_Y_MIN + DEF_BALL_R;
  localparam int YHI = DEF_Y_MAX - DEF_BALL_R;

  typedef struct {
    logic [21:0] loc;
    logic [31:0] vel;
    logic [16:0] ang;
    logic        wall;
    logic        mtop;
    logic        mbot;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ball_step_engine_if bus ();

  ball_step_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   sd_seen = 0;
  int   sd_expected = 0;

  // Reference ball: plain integers, one rally at a time
  int mx, my, mvx, mvy, mang;
  bit mover;

  function automatic int sx13(input int v);
    logic signed [12:0] t;
    t = v[12:0];
    return int'(t);
  endfunction

  function automatic int neg16(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  function automatic int neg17(input int v);
    return (v == -65536) ? 65535 : -v;
  endfunction

  function automatic logic [21:0] pack_loc(input int x, input int y);
    return {11'(x), 11'(y)};
  endfunction

  function automatic logic [31:0] pack_vel(input int vx, input int vy);
    return {16'(vx), 16'(vy)};
  endfunction

  task automatic model_load(input logic [21:0] loc, input logic [31:0] vel, input logic [16:0] ang);
    logic signed [15:0] t16;
    logic signed [16:0] t17;
    mx   = int'(loc[21:11]);
    my   = int'(loc[10:0]);
    t16  = vel[31:16];
    mvx  = int'(t16);
    t16  = vel[15:0];
    mvy  = int'(t16);
    t17  = ang;
    mang = int'(t17);
    mover = 1'b0;
  endtask

  // One frame of ball physics; the expected engine response goes on the scoreboard
  task automatic model_step(input bit paddle);
    int   vxe, nx, ny, ang;
    exp_t e;
    e.wall = 1'b0;
    e.mtop = 1'b0;
    e.mbot = 1'b0;
    vxe = mvx;
    ang = mang;
`ifdef BALL_SPIN_EN
    vxe = mvx + (mang >>> 8);
    if (vxe > 64) vxe = 64;
    if (vxe < -64) vxe = -64;
    if (mang > 0) ang = mang - 1;
    else if (mang < 0) ang = mang + 1;
    nx = mx + vxe;
`else
    nx = mx + sx13(mvx);
`endif
    if (nx < XLO) begin
      nx = 2 * XLO - nx;
      vxe = neg16(vxe);
      ang = neg17(ang);
      e.wall = 1'b1;
    end else if (nx > XHI) begin
      nx = 2 * XHI - nx;
      vxe = neg16(vxe);
      ang = neg17(ang);
      e.wall = 1'b1;
    end
    if (paddle) begin
      mvy = neg16(mvy);
      ny = my;
    end else begin
      ny = my + sx13(mvy);
      if (ny < YLO) begin
        e.mtop = 1'b1;
        ny = YLO;
        mover = 1'b1;
      end else if (ny > YHI) begin
        e.mbot = 1'b1;
        ny = YHI;
        mover = 1'b1;
      end
    end
    mx   = nx & 'h7FF;
    my   = ny & 'h7FF;
    mvx  = vxe;
    mang = ang;
    e.loc = pack_loc(mx, my);
    e.vel = pack_vel(mvx, mvy);
    e.ang = 17'(mang);
    exp_q.push_back(e);
    sd_expected++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Serve pulse, then the LOAD cycle; returns in the first RUN cycle
  task automatic do_serve(input logic [21:0] loc, input logic [31:0] vel, input logic [16:0] ang);
    bus.serve       = 1'b1;
    bus.location_in = loc;
    bus.velocity_in = vel;
    bus.angle_in    = ang;
    cyc();
    bus.serve = 1'b0;
    model_load(loc, vel, ang);
    cyc();
  endtask

  // Tick for one cycle, then let CALC finish; returns in the cycle step_done shows
  task automatic do_tick(input bit paddle);
    if (!mover) model_step(paddle);
    bus.tick       = 1'b1;
    bus.paddle_hit = paddle;
    cyc();
    bus.tick       = 1'b0;
    bus.paddle_hit = 1'b0;
    cyc();
  endtask

  // Monitor: every step_done pops one expected step; stray event pulses are errors
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.step_done) begin
        sd_seen++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL step_done unexpected: loc=%0h vel=%0h", bus.location_fb, bus.velocity_fb);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.location_fb !== mon_e.loc || bus.velocity_fb !== mon_e.vel ||
              bus.angle_fb !== mon_e.ang || bus.wall_hit !== mon_e.wall ||
              bus.miss_top !== mon_e.mtop || bus.miss_bot !== mon_e.mbot) begin
            fails++;
            $display("FAIL step result: got loc=%0h vel=%0h ang=%0h w=%0b t=%0b b=%0b, expected loc=%0h vel=%0h ang=%0h w=%0b t=%0b b=%0b",
                     bus.location_fb, bus.velocity_fb, bus.angle_fb, bus.wall_hit, bus.miss_top, bus.miss_bot,
                     mon_e.loc, mon_e.vel, mon_e.ang, mon_e.wall, mon_e.mtop, mon_e.mbot);
          end
        end
      end else if (bus.wall_hit || bus.miss_top || bus.miss_bot) begin
        tests++;
        fails++;
        $display("FAIL stray pulse: w=%0b t=%0b b=%0b, expected none without step_done",
                 bus.wall_hit, bus.miss_top, bus.miss_bot);
      end
    end
  end

  initial begin
    bus.serve       = 1'b0;
    bus.tick        = 1'b0;
    bus.paddle_hit  = 1'b0;
    bus.location_in = '0;
    bus.velocity_in = '0;
    bus.angle_in    = '0;
    mover = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset value_select", 64'(bus.value_select), 64'd0);
    check("reset location_fb", 64'(bus.location_fb), 64'd0);
    check("reset velocity_fb", 64'(bus.velocity_fb), 64'd0);
    check("reset angle_fb", 64'(bus.angle_fb), 64'd0);
    check("reset pulses", 64'({bus.step_done, bus.wall_hit, bus.miss_top, bus.miss_bot}), 64'd0);
    rst = 1'b0;
    cyc();

    // First serve and plain step
    do_serve(pack_loc(320, 240), pack_vel(3, -2), 17'd0);
    check("value_select after LOAD", 64'(bus.value_select), 64'd1);
    check("location_fb after LOAD", 64'(bus.location_fb), 64'(pack_loc(320, 240)));
    do_tick(1'b0);

    // Right-wall reflection
    do_serve(pack_loc(637, 240), pack_vel(5, 0), 17'd100);
    do_tick(1'b0);

    // Landing exactly on the bounds, then crossing them
    do_serve(pack_loc(630, 8), pack_vel(5, -4), 17'd7);
    do_tick(1'b0);
    do_tick(1'b0);

    // Saturating negation of vy and angle minimums
    do_serve(pack_loc(634, 100), pack_vel(5, -32768), 17'h10000);
    do_tick(1'b1);

    // Paddle contact beats the miss
    do_serve(pack_loc(320, 6), pack_vel(1, -4), 17'd0);
    do_tick(1'b1);

    // Top miss, then OVER ignores ticks
    do_serve(pack_loc(320, 6), pack_vel(1, -4), 17'd0);
    do_tick(1'b0);
    check("value_select in OVER", 64'(bus.value_select), 64'd0);
    do_tick(1'b0);
    cyc();
    check("no step_done in OVER", 64'(sd_seen), 64'(sd_expected));

    // Bottom miss
    do_serve(pack_loc(100, 474), pack_vel(-3, 3), 17'd0);
    do_tick(1'b0);

    // Serve and tick together in RUN: serve wins
    do_serve(pack_loc(200, 200), pack_vel(2, 2), 17'd0);
    bus.serve       = 1'b1;
    bus.tick        = 1'b1;
    bus.location_in = pack_loc(50, 60);
    bus.velocity_in = pack_vel(-1, 1);
    bus.angle_in    = 17'd3;
    cyc();
    bus.serve = 1'b0;
    bus.tick  = 1'b0;
    model_load(pack_loc(50, 60), pack_vel(-1, 1), 17'd3);
    check("value_select in LOAD", 64'(bus.value_select), 64'd0);
    cyc();
    check("location_fb after serve+tick", 64'(bus.location_fb), 64'(pack_loc(50, 60)));
    repeat (3) cyc();
    check("no step for serve+tick", 64'(sd_seen), 64'(sd_expected));

    // A tick held into CALC is not queued
    model_step(1'b0);
    bus.tick = 1'b1;
    cyc();
    cyc();
    bus.tick = 1'b0;
    repeat (3) cyc();
    check("tick in CALC ignored", 64'(sd_seen), 64'(sd_expected));

    // Serve during CALC: the step still pulses, then LOAD overwrites
    model_step(1'b0);
    bus.tick = 1'b1;
    cyc();
    bus.tick        = 1'b0;
    bus.serve       = 1'b1;
    bus.location_in = pack_loc(400, 300);
    bus.velocity_in = pack_vel(4, -4);
    bus.angle_in    = 17'd0;
    cyc();
    bus.serve = 1'b0;
    model_load(pack_loc(400, 300), pack_vel(4, -4), 17'd0);
    cyc();
    check("location_fb after serve in CALC", 64'(bus.location_fb), 64'(pack_loc(400, 300)));

    // Spin saturation case (plain step when spin is not built in)
    do_serve(pack_loc(320, 240), pack_vel(60, 0), 17'd2048);
    do_tick(1'b0);

    // Random rallies
    for (int r = 0; r < 25; r++) begin
      do_serve(pack_loc($urandom_range(XHI, XLO), $urandom_range(460, 20)),
               pack_vel(int'($urandom_range(40, 0)) - 20, int'($urandom_range(24, 0)) - 12),
               17'($urandom));
      for (int k = 0; k < int'($urandom_range(15, 3)); k++) begin
        repeat ($urandom_range(2, 0)) cyc();
        do_tick($urandom_range(3, 0) == 0);
      end
    end

    // Asynchronous reset in the middle of a rally
    do_serve(pack_loc(300, 200), pack_vel(1, 1), 17'd9);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async reset location_fb", 64'(bus.location_fb), 64'd0);
    check("async reset value_select", 64'(bus.value_select), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mover = 1'b1;
    do_tick(1'b0);
    cyc();
    check("tick in IDLE ignored", 64'(sd_seen), 64'(sd_expected));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    check("step_done count", 64'(sd_seen), 64'(sd_expected));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
